// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline sequencer.
//   CTRL_Wire_Bus   : per-stage register control (Normal / Block / Flush)
//   pc_sel_t        : PC source select (SEQ / BRANCH / TRAP)
//   pctrl_state_e   : sequencer state (RUN / MEM_WAIT / TRAP)
package pipe_ctrl_pkg;

  typedef logic [1:0] CTRL_Wire_Bus;

  localparam CTRL_Wire_Bus CTRL_STATE_Normal = 2'b00;  // register loads
  localparam CTRL_Wire_Bus CTRL_STATE_Block  = 2'b01;  // register holds
  localparam CTRL_Wire_Bus CTRL_STATE_Flush  = 2'b10;  // register loads a bubble

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_SEL_SEQ    = 2'd0;
  localparam pc_sel_t PC_SEL_BRANCH = 2'd1;
  localparam pc_sel_t PC_SEL_TRAP   = 2'd2;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'd0,
    PCTRL_MEM_WAIT = 2'd1,
    PCTRL_TRAP     = 2'd2
  } pctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_reg.sv
// pipe_ctrl_reg: generic enabled register with asynchronous active-low clear.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low clear to ResetVal
//   i_wen   : load enable
//   i_d     : next value
//   o_q     : registered value
module pipe_ctrl_reg #(
  parameter int unsigned        Width    = 1,
  parameter logic [Width-1:0]   ResetVal = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wen,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= ResetVal;
    end else if (i_wen) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the five-stage pipeline. Produces Normal/Block/Flush
// controls for the IF_ID, ID_EX, EX_MEM and MEM_WB registers plus PC write-enable and
// source select, resolving traps, data-memory stalls, branch redirects, load-use
// hazards and fetch-not-ready. Outputs are Mealy (state + current inputs).
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   if_ready_i        : fetch has a valid instruction
//   load_use_i        : ID depends on the load currently in EX
//   branch_taken_i    : EX resolved a taken branch/jump
//   mem_req_i/ack_i   : MEM holds a load/store / memory completes it this cycle
//   trap_i            : MEM raises an exception or interrupt
//   *_ctrl_o          : per-stage-register control
//   pc_wen_o/pc_sel_o : PC update enable and source select
//   mem_cancel_o      : abort the outstanding data access
//   busy_o            : controller is in MEM_WAIT or TRAP
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TRAP_DRAIN = 2,  // legal range 1..7
  parameter int unsigned CNT_W      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         if_ready_i,
  input  logic         load_use_i,
  input  logic         branch_taken_i,
  input  logic         mem_req_i,
  input  logic         mem_ack_i,
  input  logic         trap_i,
  output CTRL_Wire_Bus if_id_ctrl_o,
  output CTRL_Wire_Bus id_ex_ctrl_o,
  output CTRL_Wire_Bus ex_mem_ctrl_o,
  output CTRL_Wire_Bus mem_wb_ctrl_o,
  output logic         pc_wen_o,
  output pc_sel_t      pc_sel_o,
  output logic         mem_cancel_o,
  output logic         busy_o
);

  localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(TRAP_DRAIN - 1);

  logic [1:0]       r_state_raw;
  logic [CNT_W-1:0] r_cnt;
  pctrl_state_e     w_state;
  pctrl_state_e     w_state_d;
  logic [CNT_W-1:0] w_cnt_d;

  // Front-end hazard resolution (branch > load-use > fetch), shared by RUN and the
  // MEM_WAIT ack cycle.
  CTRL_Wire_Bus w_fe_if_id;
  CTRL_Wire_Bus w_fe_id_ex;
  logic         w_fe_pc_wen;
  pc_sel_t      w_fe_pc_sel;

  pipe_ctrl_reg #(
    .Width    (2),
    .ResetVal (PCTRL_RUN)
  ) u_state_reg (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_wen   (1'b1),
    .i_d     (w_state_d),
    .o_q     (r_state_raw)
  );

  pipe_ctrl_reg #(
    .Width    (CNT_W),
    .ResetVal ('0)
  ) u_cnt_reg (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_wen   (1'b1),
    .i_d     (w_cnt_d),
    .o_q     (r_cnt)
  );

  assign w_state = pctrl_state_e'(r_state_raw);

  always_comb begin
    w_fe_if_id  = CTRL_STATE_Normal;
    w_fe_id_ex  = CTRL_STATE_Normal;
    w_fe_pc_wen = 1'b1;
    w_fe_pc_sel = PC_SEL_SEQ;
    if (branch_taken_i) begin
      w_fe_if_id  = CTRL_STATE_Flush;
      w_fe_id_ex  = CTRL_STATE_Flush;
      w_fe_pc_sel = PC_SEL_BRANCH;
    end else if (load_use_i) begin
      w_fe_if_id  = CTRL_STATE_Block;
      w_fe_id_ex  = CTRL_STATE_Flush;
      w_fe_pc_wen = 1'b0;
    end else if (!if_ready_i) begin
      w_fe_if_id  = CTRL_STATE_Flush;
      w_fe_pc_wen = 1'b0;
    end
  end

  always_comb begin
    if_id_ctrl_o  = CTRL_STATE_Normal;
    id_ex_ctrl_o  = CTRL_STATE_Normal;
    ex_mem_ctrl_o = CTRL_STATE_Normal;
    mem_wb_ctrl_o = CTRL_STATE_Normal;
    pc_wen_o      = 1'b1;
    pc_sel_o      = PC_SEL_SEQ;
    mem_cancel_o  = 1'b0;
    w_state_d     = w_state;
    w_cnt_d       = r_cnt;

    unique case (w_state)
      PCTRL_RUN, PCTRL_MEM_WAIT: begin
        if (trap_i) begin
          if_id_ctrl_o  = CTRL_STATE_Flush;
          id_ex_ctrl_o  = CTRL_STATE_Flush;
          ex_mem_ctrl_o = CTRL_STATE_Flush;
          mem_wb_ctrl_o = CTRL_STATE_Flush;
          pc_wen_o      = 1'b0;
          mem_cancel_o  = (w_state == PCTRL_MEM_WAIT);
          w_cnt_d       = DrainLoad;
          w_state_d     = PCTRL_TRAP;
        end else if ((w_state == PCTRL_RUN) ? (mem_req_i && !mem_ack_i) : !mem_ack_i) begin
          // Hold the upper pipe; MEM_WB takes a bubble so the stalled op is not
          // written back once per wait cycle.
          if_id_ctrl_o  = CTRL_STATE_Block;
          id_ex_ctrl_o  = CTRL_STATE_Block;
          ex_mem_ctrl_o = CTRL_STATE_Block;
          mem_wb_ctrl_o = CTRL_STATE_Flush;
          pc_wen_o      = 1'b0;
          w_state_d     = PCTRL_MEM_WAIT;
        end else begin
          if_id_ctrl_o = w_fe_if_id;
          id_ex_ctrl_o = w_fe_id_ex;
          pc_wen_o     = w_fe_pc_wen;
          pc_sel_o     = w_fe_pc_sel;
          w_state_d    = PCTRL_RUN;
        end
      end
      PCTRL_TRAP: begin
        if_id_ctrl_o  = CTRL_STATE_Flush;
        id_ex_ctrl_o  = CTRL_STATE_Flush;
        ex_mem_ctrl_o = CTRL_STATE_Flush;
        mem_wb_ctrl_o = CTRL_STATE_Flush;
        pc_wen_o      = 1'b0;
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end else begin
          pc_wen_o  = 1'b1;
          pc_sel_o  = PC_SEL_TRAP;
          w_state_d = PCTRL_RUN;
        end
      end
      default: begin
        w_state_d = PCTRL_RUN;
      end
    endcase

    // Reset forces a quiescent pipe regardless of inputs.
    if (!rst) begin
      if_id_ctrl_o  = CTRL_STATE_Flush;
      id_ex_ctrl_o  = CTRL_STATE_Flush;
      ex_mem_ctrl_o = CTRL_STATE_Flush;
      mem_wb_ctrl_o = CTRL_STATE_Flush;
      pc_wen_o      = 1'b0;
      pc_sel_o      = PC_SEL_SEQ;
      mem_cancel_o  = 1'b0;
    end
  end

  assign busy_o = (w_state != PCTRL_RUN);

endmodule
